// File: rtl/layer_argmax_collect.sv
// layer_argmax_collect: accepts M signed elements per vector, then presents their
// maximum and the arrival index of its first occurrence.
module layer_argmax_collect #(
    parameter int M     = 8,
    parameter int WIDTH = 16,
    parameter int LOGM  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [LOGM-1:0]  idx_out
);
    typedef enum logic [1:0] {WAKE, COLLECT, OUTPUT} state_t;
    state_t state;
    logic [LOGM-1:0] cnt, idx_r, idx_nxt;
    logic signed [WIDTH-1:0] max_r, max_nxt;
    logic take, last;
    // element 0 always loads; strict > keeps the earliest index on ties
    always_comb begin
        take    = (cnt == '0) || ($signed(data_in) > max_r);
        max_nxt = take ? $signed(data_in) : max_r;
        idx_nxt = take ? cnt : idx_r;
        last    = (cnt == LOGM'(M - 1));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WAKE;
            cnt      <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            data_out <= '0;
            idx_out  <= '0;
            max_r    <= '0;
            idx_r    <= '0;
        end else begin
            case (state)
                WAKE: begin
                    state   <= COLLECT;
                    s_ready <= 1'b1;
                end
                COLLECT: if (s_valid && s_ready) begin
                    max_r <= max_nxt;
                    idx_r <= idx_nxt;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state    <= OUTPUT;
                        s_ready  <= 1'b0;
                        m_valid  <= 1'b1;
                        data_out <= max_nxt;
                        idx_out  <= idx_nxt;
                    end
                end
                OUTPUT: if (m_ready) begin
                    state   <= COLLECT;
                    m_valid <= 1'b0;
                    s_ready <= 1'b1;
                end
                default: begin
                    state   <= WAKE;
                    s_ready <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/layer_argmax_collect.md
LAYER_ARGMAX_COLLECT -- requirements
Module: layer_argmax_collect

Interface
REQ-001 The block SHALL have parameter M, default 8, giving the number of layer outputs per vector.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the signed data width.
REQ-003 The block SHALL have parameter LOGM, default 3, giving the width of the index output (clog2 of M).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  upstream layer presents data_in.
REQ-007 s_ready  output  1  block accepts data_in this cycle.
REQ-008 data_in  input  WIDTH  signed layer output (post-ReLU), one element per transfer.
REQ-009 m_valid  output  1  result available.
REQ-010 m_ready  input  1  downstream consumes the result.
REQ-011 data_out  output  WIDTH  signed maximum of the M accepted elements.
REQ-012 idx_out  output  LOGM  index (0..M-1, arrival order) of that maximum.

Function
REQ-013 The block SHALL implement states WAKE, COLLECT and OUTPUT, held in registers.
REQ-014 The block SHALL count a transfer only on a clock edge where s_valid and s_ready are both 1.
REQ-015 WAKE SHALL last exactly one cycle after reset release, with s_ready=0, then move to COLLECT.
REQ-016 In COLLECT, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-017 A 0..M-1 element counter SHALL increment on each transfer in COLLECT.
REQ-018 Element 0 SHALL load the running max and set the running index to 0, regardless of any earlier value.
REQ-019 Element k>0 SHALL replace the running max and set the running index to k only if data_in > max under signed comparison.
REQ-020 On ties, the earliest (lowest) index SHALL be retained.
REQ-021 On the transfer of element M-1, the compare SHALL be applied, the counter SHALL wrap to 0, and the state SHALL become OUTPUT on that same edge.
REQ-022 s_ready SHALL be 0 from the cycle after the last transfer.
REQ-023 m_valid SHALL rise one cycle after the last transfer, with data_out and idx_out valid in that cycle.
REQ-024 In OUTPUT, m_valid SHALL be 1, s_ready SHALL be 0, and data_out/idx_out SHALL be held stable until m_ready=1.
REQ-025 On an OUTPUT edge with m_ready=1, the state SHALL become COLLECT, m_valid SHALL be 0 and s_ready SHALL be 1 in the next cycle.
REQ-026 data_out/idx_out SHALL keep their last values until the next result is produced.
REQ-027 Accepting data and delivering a result SHALL never overlap; no element is dropped while OUTPUT stalls, because s_ready is held low.
REQ-028 Any s_valid pulse while s_ready=0 SHALL have no effect on the block's state.
REQ-029 data_in values, including negative ones, SHALL be compared as signed WIDTH-bit values; no width growth or saturation is applied.
REQ-030 m_ready asserted outside OUTPUT SHALL be ignored.

Reset
REQ-031 When reset=0, all registers SHALL clear immediately, without waiting for a clock edge.
REQ-032 Reset values: state=WAKE, counter=0, s_ready=0, m_valid=0, data_out=0, idx_out=0, running max=0, running index=0.
REQ-033 A reset asserted mid-vector or during OUTPUT SHALL discard the partial or pending result.
REQ-034 After release, the next accepted element SHALL be treated as element 0.
REQ-035 The block SHALL leave WAKE on the first rising edge after reset returns high.

Verification
REQ-036 Scenario: reset, then stream 10,3,45,7,45,0,2,1 with s_valid=1 and m_ready=1 -> m_valid=1 one cycle after the 8th transfer, data_out=45, idx_out=2, then s_ready=1 on the next cycle.
REQ-037 Scenario: stream -5,-2,-9,-2,-7,-3,-8,-6 -> data_out=-2 (0xFFFE), idx_out=1.
REQ-038 Scenario: random s_valid gaps plus m_ready=0 for 5 cycles during OUTPUT -> m_valid, data_out and idx_out are stable all 5 cycles, s_ready=0, extra s_valid is ignored, and the result is consumed on the first cycle m_ready=1.
REQ-039 Scenario: reset=0 asynchronously after 4 elements, then a full vector 1..8 -> no stale result, data_out=8, idx_out=7.
REQ-040 Scenario: two back-to-back vectors 0,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,9 -> results (0,0) then (9,7), proving running state is reinitialised at element 0.
REQ-041 Scenario: m_ready held at 1 throughout COLLECT -> no spurious m_valid and no state change.
